// File: rtl/marker_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : marker_overlay
//  Description : Draws a crosshair marker at a centroid coordinate onto a
//                12-bit pixel stream. The coordinate is accepted at any time.
//                It becomes the drawn marker only at the next frame start,
//                so a frame is never torn between two positions.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iCLK            in   1   pixel clock
//    iRST            in   1   asynchronous active-high reset
//    iX / iY         in   11  marker column / row
//    iVALID_COORD    in   1   strobe, iX/iY valid this cycle
//    iColor          in   12  input pixel
//    iDVAL           in   1   input pixel valid
//    oColor          out  12  output pixel (input or MARKER_COLOR)
//    oDVAL           out  1   output pixel valid (iDVAL delayed one cycle)
//    oMARKER_ACTIVE  out  1   marker currently shown
//  Optional feature macro
//    MARKER_TIMEOUT_EN : hide the marker after TIMEOUT_FRAMES frames without
//                        a new coordinate.
// ============================================================================
module marker_overlay #(
    parameter int          FRAME_W      = 480,
    parameter int          FRAME_H      = 640,
    parameter int          ARM          = 8,
    parameter logic [11:0] MARKER_COLOR = 12'hF00
`ifdef MARKER_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_FRAMES = 4
`endif
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iX,
    input  logic [10:0] iY,
    input  logic        iVALID_COORD,
    input  logic [11:0] iColor,
    input  logic        iDVAL,
    output logic [11:0] oColor,
    output logic        oDVAL,
    output logic        oMARKER_ACTIVE
);

    localparam logic [10:0]        LAST_COL = 11'(FRAME_W - 1);
    localparam logic [10:0]        LAST_ROW = 11'(FRAME_H - 1);
    localparam logic signed [11:0] ARM_S    = 12'(ARM);

    typedef enum logic [1:0] {
        NO_COORD = 2'd0,
        PENDING  = 2'd1,
        SHOW     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d, row_q, row_d;
    logic [10:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic        pend_v_q, pend_v_d;
    logic [10:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [11:0] color_q, color_d;
    logic        dval_q, dval_d;
    logic        active_q, active_d;

    logic               fs;
    logic               accept;
    logic               load;
    logic               hit;
    logic signed [11:0] dx, dy;

`ifdef MARKER_TIMEOUT_EN
    localparam int          CNT_W   = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_FRAMES);
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
`endif

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        pend_v_d = pend_v_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        state_d  = state_q;

        fs     = iDVAL && (col_q == 11'd0) && (row_q == 11'd0);
        accept = iVALID_COORD && (iX < 11'(FRAME_W)) && (iY < 11'(FRAME_H));
        // A frame start swaps in a new coordinate either from the pending
        // register or straight from a strobe arriving on that very cycle.
        load   = fs && (accept || pend_v_q);

        if (iDVAL) begin
            if (col_q == LAST_COL) begin
                col_d = 11'd0;
                row_d = (row_q == LAST_ROW) ? 11'd0 : row_q + 11'd1;
            end else begin
                col_d = col_q + 11'd1;
            end
        end

        if (fs) begin
            if (accept) begin
                act_x_d = iX;
                act_y_d = iY;
            end else if (pend_v_q) begin
                act_x_d = pend_x_q;
                act_y_d = pend_y_q;
            end
            pend_v_d = 1'b0;
        end else if (accept) begin
            pend_x_d = iX;
            pend_y_d = iY;
            pend_v_d = 1'b1;
        end

`ifdef MARKER_TIMEOUT_EN
        frame_cnt_d   = frame_cnt_q;
        frame_cnt_inc = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;
        // The count is the number of frames the current coordinate has been
        // shown; loading a new coordinate restarts it.
        if (fs && (state_q == SHOW)) begin
            frame_cnt_d = load ? '0 : frame_cnt_inc;
        end else if (accept) begin
            frame_cnt_d = '0;
        end
`endif

        case (state_q)
            NO_COORD: begin
                if (load)        state_d = SHOW;
                else if (accept) state_d = PENDING;
            end
            PENDING: begin
                if (fs) state_d = SHOW;
            end
            SHOW: begin
`ifdef MARKER_TIMEOUT_EN
                if (fs && !load && (frame_cnt_inc == CNT_MAX)) state_d = NO_COORD;
`endif
            end
            default: state_d = NO_COORD;
        endcase

        // Decisions use the post-update state/coord so the frame-start pixel
        // already belongs to the new frame's marker.
        dx  = $signed({1'b0, col_q}) - $signed({1'b0, act_x_d});
        dy  = $signed({1'b0, row_q}) - $signed({1'b0, act_y_d});
        hit = (state_d == SHOW) &&
              (((dy == 12'sd0) && (dx >= -ARM_S) && (dx <= ARM_S)) ||
               ((dx == 12'sd0) && (dy >= -ARM_S) && (dy <= ARM_S)));

        dval_d   = iDVAL;
        color_d  = iDVAL ? (hit ? MARKER_COLOR : iColor) : color_q;
        active_d = (state_d == SHOW);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= NO_COORD;
            col_q    <= 11'd0;
            row_q    <= 11'd0;
            pend_x_q <= 11'd0;
            pend_y_q <= 11'd0;
            pend_v_q <= 1'b0;
            act_x_q  <= 11'd0;
            act_y_q  <= 11'd0;
            color_q  <= 12'd0;
            dval_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            pend_v_q <= pend_v_d;
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
            color_q  <= color_d;
            dval_q   <= dval_d;
            active_q <= active_d;
        end
    end

`ifdef MARKER_TIMEOUT_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) frame_cnt_q <= '0;
        else      frame_cnt_q <= frame_cnt_d;
    end
`endif

    assign oColor         = color_q;
    assign oDVAL          = dval_q;
    assign oMARKER_ACTIVE = active_q;

endmodule
`default_nettype wire

// File: tb/tb_marker_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_marker_overlay
//  Description : Self-checking bench for marker_overlay on a reduced frame
//                (40x30, arm 8) with random pixel data and random iDVAL gaps.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_marker_overlay;

    localparam int          W    = 40;
    localparam int          H    = 30;
    localparam int          ARMV = 8;
    localparam logic [11:0] MARK = 12'hF00;
`ifdef MARKER_TIMEOUT_EN
    localparam int          TO   = 4;
`endif

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [10:0] iX, iY;
    logic        iVALID_COORD;
    logic [11:0] iColor;
    logic        iDVAL;
    logic [11:0] oColor;
    logic        oDVAL;
    logic        oMARKER_ACTIVE;

    marker_overlay #(
        .FRAME_W      (W),
        .FRAME_H      (H),
        .ARM          (ARMV),
        .MARKER_COLOR (MARK)
    ) dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iX             (iX),
        .iY             (iY),
        .iVALID_COORD   (iVALID_COORD),
        .iColor         (iColor),
        .iDVAL          (iDVAL),
        .oColor         (oColor),
        .oDVAL          (oDVAL),
        .oMARKER_ACTIVE (oMARKER_ACTIVE)
    );

    always #5 iCLK = ~iCLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: current scan position, pending coordinate, and the
    // coordinate chosen for the frame in progress.
    int          m_col, m_row;
    bit          m_show, m_pend_v;
    int          m_act_x, m_act_y, m_pend_x, m_pend_y, m_age;
    logic [11:0] m_color;
    int          dut_marks, edge_marks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_show = 0; m_pend_v = 0;
        m_act_x = 0; m_act_y = 0; m_pend_x = 0; m_pend_y = 0; m_age = 0;
        m_color = 12'h000;
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        model_reset();
        #2;
        check("rst_color", oColor, 12'h000);
        check("rst_dval", oDVAL, 1'b0);
        check("rst_active", oMARKER_ACTIVE, 1'b0);
        @(posedge iCLK);
        #1 iRST = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then check outputs.
    task automatic cycle(input bit dval, input bit strobe, input int sx, input int sy);
        logic [11:0] c;
        bit          accept, fs, hit;
        int          dx, dy, pc, pr;
        c = 12'($urandom);
        if (c == MARK) c = 12'h0F0;
        iDVAL = dval; iColor = c; iVALID_COORD = strobe;
        iX = 11'(sx); iY = 11'(sy);

        accept = strobe && sx < W && sy < H;
        fs     = dval && m_col == 0 && m_row == 0;
        if (fs) begin
            if (accept) begin
                m_act_x = sx; m_act_y = sy; m_show = 1; m_pend_v = 0; m_age = 0;
            end else if (m_pend_v) begin
                m_act_x = m_pend_x; m_act_y = m_pend_y; m_show = 1; m_pend_v = 0; m_age = 0;
            end else if (m_show) begin
`ifdef MARKER_TIMEOUT_EN
                m_age++;
                if (m_age >= TO) m_show = 0;
`endif
            end
        end else if (accept) begin
            m_pend_x = sx; m_pend_y = sy; m_pend_v = 1;
        end

        pc = m_col; pr = m_row;
        dx = pc - m_act_x; dy = pr - m_act_y;
        hit = m_show && ((dy == 0 && dx >= -ARMV && dx <= ARMV) ||
                         (dx == 0 && dy >= -ARMV && dy <= ARMV));
        if (dval) begin
            m_color = hit ? MARK : c;
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end
        end

        @(posedge iCLK);
        #1;
        check("odval", oDVAL, dval);
        check("ocolor", oColor, m_color);
        check("active", oMARKER_ACTIVE, m_show);
        if (dval && oColor == MARK) begin
            dut_marks++;
            if (pr == H - 1 || pc == W - 1) edge_marks++;
        end
        iVALID_COORD = 1'b0;
    endtask

    // One full frame with random idle gaps; optional strobes at given pixels
    // (pixel 0 is the frame-start pixel).
    task automatic run_frame(input int s1_at, input int x1, input int y1,
                             input int s2_at, input int x2, input int y2);
        dut_marks = 0; edge_marks = 0;
        for (int p = 0; p < W * H; p++) begin
            while ($urandom_range(3) == 0) cycle(1'b0, 1'b0, 0, 0);
            if (p == s1_at)      cycle(1'b1, 1'b1, x1, y1);
            else if (p == s2_at) cycle(1'b1, 1'b1, x2, y2);
            else                 cycle(1'b1, 1'b0, 0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        iRST = 1'b1; iX = '0; iY = '0; iVALID_COORD = 1'b0; iColor = '0; iDVAL = 1'b0;
        dut_marks = 0; edge_marks = 0;
        model_reset();
        do_reset();

        // Plain frame, no coordinate.
        run_frame(-1, 0, 0, -1, 0, 0);
        check("idle_marks", dut_marks, 0);

        // Mid-frame strobe: this frame unmarked, next frame full crosshair.
        run_frame(W * H / 2 + 3, 20, 15, -1, 0, 0);
        check("strobe_frame_marks", dut_marks, 0);
        run_frame(-1, 0, 0, -1, 0, 0);
        check("cross_marks", dut_marks, 33);

        // Corner coordinate: arms clip at the frame edges.
        run_frame(100, 2, 0, -1, 0, 0);
        check("old_cross_marks", dut_marks, 33);
        run_frame(-1, 0, 0, -1, 0, 0);
        check("corner_marks", dut_marks, 19);
        check("corner_edge", edge_marks, 0);

        // Out-of-range strobes are ignored.
        do_reset();
        run_frame(50, W, 10, 300, 5, H);
        check("oob_marks", dut_marks, 0);
        check("oob_active", oMARKER_ACTIVE, 1'b0);
        run_frame(-1, 0, 0, -1, 0, 0);
        check("oob_next_marks", dut_marks, 0);

        // Strobe on the frame-start pixel plus a later one in the same frame.
        run_frame(0, 10, 10, 600, 30, 20);
        check("bypass_marks", dut_marks, 33);
        run_frame(-1, 0, 0, -1, 0, 0);
        check("second_marks", dut_marks, 33);

        // Persistence (or timeout when enabled).
        for (int f = 0; f < 5; f++) begin
            run_frame(-1, 0, 0, -1, 0, 0);
`ifdef MARKER_TIMEOUT_EN
            check("persist_marks", dut_marks, (f < 3) ? 33 : 0);
`else
            check("persist_marks", dut_marks, 33);
`endif
        end

        // Reset in the middle of a frame with a pending coordinate.
        for (int p = 0; p < W * H / 2 + 7; p++) cycle(1'b1, p == 20, 20, 15);
        do_reset();
        run_frame(-1, 0, 0, -1, 0, 0);
        check("post_rst_marks", dut_marks, 0);
        run_frame(5, 20, 15, -1, 0, 0);
        check("post_rst_strobe", dut_marks, 0);
        run_frame(-1, 0, 0, -1, 0, 0);
        check("post_rst_cross", dut_marks, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
